// File: rtl/gnn_result_collector.sv
// gnn_result_collector: captures the eight GNN node scores as their ready flags assert,
// then drains them in slot order over a valid/ready stream and reports per-node class decisions.
module gnn_result_collector #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [20:0] out0_node0,
    input  logic signed [20:0] out0_node1,
    input  logic signed [20:0] out0_node2,
    input  logic signed [20:0] out0_node3,
    input  logic signed [20:0] out1_node0,
    input  logic signed [20:0] out1_node1,
    input  logic signed [20:0] out1_node2,
    input  logic signed [20:0] out1_node3,
    input  logic               out10_ready_node0,
    input  logic               out10_ready_node1,
    input  logic               out10_ready_node2,
    input  logic               out10_ready_node3,
    input  logic               out11_ready_node0,
    input  logic               out11_ready_node1,
    input  logic               out11_ready_node2,
    input  logic               out11_ready_node3,
    output logic signed [20:0] res_data,
    output logic        [2:0]  res_idx,
    output logic               res_miss,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic        [3:0]  node_class
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic signed [20:0] slot [8];
    logic signed [20:0] din  [8];
    logic signed [20:0] eff  [8];
    logic        [7:0]  rdy, mask, take, mask_nx;
    logic        [15:0] cnt;
    logic        [2:0]  ptr;
    logic        [3:0]  cls;
    logic               full, expire, fire;

    always_comb begin
        din[0] = out0_node0;
        din[1] = out1_node0;
        din[2] = out0_node1;
        din[3] = out1_node1;
        din[4] = out0_node2;
        din[5] = out1_node2;
        din[6] = out0_node3;
        din[7] = out1_node3;
        rdy = {out11_ready_node3, out10_ready_node3, out11_ready_node2, out10_ready_node2,
               out11_ready_node1, out10_ready_node1, out11_ready_node0, out10_ready_node0};
    end

    // Only the first assertion of each flag is taken; later ones leave the slot untouched.
    assign take    = (state == CAPTURE) ? (rdy & ~mask) : 8'h00;
    assign mask_nx = mask | take;
    assign full    = mask_nx == 8'hFF;
    assign expire  = cnt == 16'(TIMEOUT_CYCLES - 1);
    assign fire    = (state == DRAIN) && res_ready;

    // Missing slots score as 0 so an absent node never wins on stale data.
    always_comb begin
        for (int k = 0; k < 8; k++) eff[k] = mask[k] ? slot[k] : 21'sd0;
        for (int n = 0; n < 4; n++) cls[n] = eff[2*n+1] > eff[2*n];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CAPTURE : IDLE;
            CAPTURE: state_nx = (full || expire) ? DRAIN : CAPTURE;
            DRAIN:   state_nx = (res_ready && ptr == 3'd7) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask       <= '0;
            cnt        <= '0;
            ptr        <= '0;
            timeout    <= 1'b0;
            node_class <= '0;
            for (int k = 0; k < 8; k++) slot[k] <= '0;
        end else begin
            if (state == IDLE && start) begin
                mask       <= '0;
                cnt        <= '0;
                ptr        <= '0;
                timeout    <= 1'b0;
                node_class <= '0;
            end
            if (state == CAPTURE) begin
                mask <= mask_nx;
                cnt  <= cnt + 16'd1;
                for (int k = 0; k < 8; k++) if (take[k]) slot[k] <= din[k];
                if (!full && expire) timeout <= 1'b1;
            end
            if (fire) begin
                ptr <= ptr + 3'd1;
                if (ptr == 3'd7) node_class <= cls;
            end
        end
    end

    assign busy      = (state == CAPTURE) || (state == DRAIN);
    assign done      = state == DONE;
    assign res_valid = state == DRAIN;
    assign res_idx   = res_valid ? ptr : 3'd0;
    assign res_miss  = res_valid && !mask[ptr];
    assign res_data  = res_valid ? eff[ptr] : 21'sd0;
endmodule

// File: doc/gnn_result_collector.md
# gnn_result_collector

Receive-side companion to the GNN accelerator `top`. It captures the eight 21-bit signed node outputs as their per-output ready flags assert, and holds them until the set is complete or a timeout expires. It then drains them in fixed order over a valid/ready stream and reports a per-node class decision. It sits between `top` and the host-facing result path, replacing bench-side sampling of `out*_node*`.

## Interface
- `TIMEOUT_CYCLES`, default 64: capture-window length in cycles, counted from entry to CAPTURE. Legal range 2..65535.
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begins a capture window; honoured only in IDLE
- `out0_node0..out0_node3`  in  21 each  signed class-0 score per node
- `out1_node0..out1_node3`  in  21 each  signed class-1 score per node
- `out10_ready_node0..3`, `out11_ready_node0..3`  in  1 each  level ready flags for `out0_nodeN` and `out1_nodeN` respectively
- `res_data`  out  21  signed result beat
- `res_idx`  out  3  slot index of beat: 2*node + class
- `res_miss`  out  1  beat carries an uncaptured slot; `res_data` is 0
- `res_valid`  out  1  beat valid
- `res_ready`  in  1  downstream accept
- `busy`  out  1  high in CAPTURE and DRAIN
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `timeout`  out  1  sticky; the window expired with slots missing; cleared by the next accepted `start` or by `rst`
- `node_class`  out  4  bit N = 1 iff `out1_nodeN` > `out0_nodeN` (signed compare); updated on entry to DONE

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE. Reset: state IDLE. All outputs 0, capture mask 0, stored slots 0.
- **IDLE:** `start` moves to CAPTURE. On the same edge, clear the mask, the timeout counter and `timeout`.
- **CAPTURE:**
  - Slot k (k = 2*node + class) latches its input on the first edge where its ready flag is high and `mask[k]` is 0. That edge also sets `mask[k]`.
  - A ready flag that stays high or re-asserts on a captured slot is ignored. The first value is kept.
  - Any number of slots may capture on the same edge.
  - If the mask, including this edge's captures, equals 8'hFF, the state moves to DRAIN on that edge.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1, the state moves to DRAIN and `timeout` is set. The final edge's captures still count.
- **DRAIN:**
  - Emits slots 0..7 in order: node0 class0, node0 class1, node1 class0, and so on.
  - `res_idx` is the slot. `res_data` is the stored value, or 0 with `res_miss`=1 if `mask[k]`=0.
  - A beat transfers on an edge with `res_valid` and `res_ready` both high.
  - `res_valid`, `res_data`, `res_idx` and `res_miss` stay stable while the beat is not accepted.
  - After the slot-7 transfer, the state moves to DONE. `res_valid` drops on that same edge.
- **DONE:**
  - `done` is 1 for exactly one cycle. `node_class` is computed from the stored slots; missing slots count as 0.
  - Next edge: IDLE. `node_class` and `timeout` hold until the next accepted `start`.
- `start` outside IDLE is ignored. A `start` level held from DONE into IDLE starts a new window.
- `rst` in any state, including mid-drain, returns to IDLE with all outputs 0 on that edge. No partial beat is completed.

## Timing
- Capture latency: a value presented with its ready flag at edge t is stored at edge t.
- First beat: `res_valid`=1 in the cycle after the edge that completes the mask or expires the window.
- Throughput: one beat per cycle under constant `res_ready`. Minimum DRAIN length is 8 cycles; `done` asserts in the cycle after the eighth transfer.
- Minimum full transaction: `start` edge, then 1 capture edge, 8 drain edges, 1 DONE cycle.
- `busy` is registered and tracks state: high from the edge after accepted `start` until the DONE entry edge.
- Timeout: with no captures, DRAIN is entered exactly `TIMEOUT_CYCLES` edges after the `start` edge.

## Test plan
- **All inputs 486000, all eight ready flags high together one cycle after `start`:** eight beats of 486000, idx 0..7, `res_miss`=0. `node_class`=4'b0000. `timeout`=0. `done` pulses once.
- **Node0..3 scores (-6358,-4188), (-6309,-4455), (-6287,-4587), (-6309,-4455), ready flags staggered one per cycle:** beats appear in slot order regardless of arrival order. `node_class`=4'b1111.
- **`res_ready` toggled 1,0,0,1,... during DRAIN:** no beat is dropped or duplicated, and data is stable while stalled. Changing `out0_node0` after capture does not alter beat 0.
- **`TIMEOUT_CYCLES`=8, only node0 and node1 flags asserted:** after 8 edges `timeout`=1. Slots 4..7 emit 0 with `res_miss`=1.
- **Ready flag re-asserted with a new value (-16) after capture of 15:** the beat carries 15.
- **`rst` asserted during beat 3 of DRAIN:** the next cycle shows IDLE, `res_valid`=0, `busy`=0, `done`=0. A new `start` produces a clean eight-beat transaction.
